// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the 16-bit pipelined core.
// Define IF_FETCH_COUNT_EN to build the saturating fetch counter behind fetch_count.
module if_id_stage #(
  parameter int unsigned        ADDR_W       = 16,
  parameter int unsigned        INSTR_W      = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(16'h3000)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               if_flush,
  input  logic               take_target,
  input  logic [ADDR_W-1:0]  target_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc_next,
  output logic               id_valid,
  output logic [3:0]         opcode,
  output logic [3:0]         func,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  id_pc_next_q, id_pc_next_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic               halted_q, halted_d;

  logic [ADDR_W-1:0]  pc_plus2;
  logic [ADDR_W-1:0]  target_aligned;
  logic               halt_seen;
  logic               fetch_go;

  assign pc_plus2       = pc_q + ADDR_W'(2);
  assign target_aligned = target_pc & ~ADDR_W'(1);

  // A halt word only retires once it is a real instruction and ID is not stalled.
  assign halt_seen = id_valid_q && (id_instr_q[INSTR_W-1 -: 4] == 4'hF) && !stall;
  assign fetch_go  = (state_q == RUN) && !halt_seen && !take_target && !if_flush && !stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_instr_d   = id_instr_q;
    id_pc_next_d = id_pc_next_q;
    id_valid_d   = id_valid_q;
    halted_d     = halted_q;
    case (state_q)
      RUN: begin
        if (halt_seen) begin
          state_d    = HALTED;
          halted_d   = 1'b1;
          id_instr_d = BUBBLE_INSTR;
          id_valid_d = 1'b0;
        end else if (take_target) begin
          pc_d       = target_aligned;
          id_instr_d = BUBBLE_INSTR;
          id_valid_d = 1'b0;
        end else if (if_flush) begin
          id_instr_d = BUBBLE_INSTR;
          id_valid_d = 1'b0;
        end else if (fetch_go) begin
          pc_d         = pc_plus2;
          id_instr_d   = imem_data;
          id_pc_next_d = pc_plus2;
          id_valid_d   = 1'b1;
        end
      end
      HALTED:  halted_d = 1'b1;
      default: state_d  = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      id_instr_q   <= BUBBLE_INSTR;
      id_pc_next_q <= '0;
      id_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_instr_q   <= id_instr_d;
      id_pc_next_q <= id_pc_next_d;
      id_valid_q   <= id_valid_d;
      halted_q     <= halted_d;
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (fetch_go && (fetch_count_q != 16'hFFFF))
      fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fetch_count_q <= 16'h0000;
    else        fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 16'h0000;
`endif

  assign imem_addr  = pc_q;
  assign id_instr   = id_instr_q;
  assign id_pc_next = id_pc_next_q;
  assign id_valid   = id_valid_q;
  assign halted     = halted_q;
  assign opcode     = id_instr_q[INSTR_W-1 -: 4];
  assign func       = id_instr_q[3:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized redirect/stall/flush
// traffic compared against a rule-level reference model.
module tb_if_id_stage;

  localparam logic [15:0] BUBBLE = 16'h3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_addr, imem_data;
  logic        stall = 1'b0, if_flush = 1'b0, take_target = 1'b0;
  logic [15:0] target_pc = 16'h0000;
  logic [15:0] id_instr, id_pc_next, fetch_count;
  logic        id_valid, halted;
  logic [3:0]  opcode, func;

  logic [15:0] mem [0:65535];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc, m_instr, m_pcn, m_count;
  logic        m_valid, m_halted;

  if_id_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .if_flush(if_flush), .take_target(take_target), .target_pc(target_pc),
    .id_instr(id_instr), .id_pc_next(id_pc_next), .id_valid(id_valid),
    .opcode(opcode), .func(func), .halted(halted), .fetch_count(fetch_count)
  );

  function automatic logic [15:0] exp_count();
`ifdef IF_FETCH_COUNT_EN
    return m_count;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = BUBBLE; m_pcn = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_count = 16'h0000;
  endtask

  // One clock edge of the machine, expressed as the ordered rules of the stage.
  task automatic model_edge();
    logic [15:0] fetched;
    fetched = mem[m_pc];
    if (m_halted) return;
    if (m_valid && m_instr[15:12] == 4'hF && !stall) begin
      m_instr = BUBBLE; m_valid = 1'b0; m_halted = 1'b1;
    end else if (take_target) begin
      m_pc = {target_pc[15:1], 1'b0}; m_instr = BUBBLE; m_valid = 1'b0;
    end else if (if_flush) begin
      m_instr = BUBBLE; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = fetched; m_pcn = m_pc + 16'd2; m_valid = 1'b1; m_pc = m_pc + 16'd2;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic tt, input logic [15:0] tgt);
    stall = st; if_flush = fl; take_target = tt; target_pc = tgt;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc got %h want 0000", imem_addr); end
    checks++; if (id_instr !== BUBBLE) begin errors++; $display("[TB] FAIL reset_instr got %h want 3000", id_instr); end
    checks++; if (id_pc_next !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pcn got %h want 0000", id_pc_next); end
    checks++; if (id_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got v=%b h=%b want 0 0", id_valid, halted); end
    checks++; if (fetch_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_count got %h want 0000", fetch_count); end
    checks++; if (opcode !== 4'h3 || func !== 4'h0) begin errors++; $display("[TB] FAIL reset_decode got %h/%h want 3/0", opcode, func); end
    @(posedge clk); #3;
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    mem[16'h0000] = 16'h0123; mem[16'h0002] = 16'h0456;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    checks++; if (id_instr !== 16'h0123) begin errors++; $display("[TB] FAIL seq_instr0 got %h want 0123", id_instr); end
    checks++; if (id_pc_next !== 16'h0002) begin errors++; $display("[TB] FAIL seq_pcn0 got %h want 0002", id_pc_next); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid0 got %b want 1", id_valid); end
    checks++; if (opcode !== 4'h0 || func !== 4'h3) begin errors++; $display("[TB] FAIL seq_decode got %h/%h want 0/3", opcode, func); end
    step();
    checks++; if (id_instr !== 16'h0456) begin errors++; $display("[TB] FAIL seq_instr1 got %h want 0456", id_instr); end
    checks++; if (imem_addr !== 16'h0004) begin errors++; $display("[TB] FAIL seq_addr1 got %h want 0004", imem_addr); end
    checks++; if (fetch_count !== exp_count()) begin errors++; $display("[TB] FAIL seq_count got %h want %h", fetch_count, exp_count()); end
  endtask

  task automatic test_stall();
    mem[16'h0004] = 16'h0789;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 16'h0004 || id_instr !== 16'h0456) begin errors++; $display("[TB] FAIL stall_hold got pc=%h instr=%h want 0004 0456", imem_addr, id_instr); end
      checks++; if (fetch_count !== exp_count()) begin errors++; $display("[TB] FAIL stall_count got %h want %h", fetch_count, exp_count()); end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    checks++; if (id_instr !== 16'h0789 || imem_addr !== 16'h0006) begin errors++; $display("[TB] FAIL stall_resume got instr=%h pc=%h want 0789 0006", id_instr, imem_addr); end
  endtask

  task automatic test_redirect();
    mem[16'h0040] = 16'h0A5A;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0041);
    step();
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("[TB] FAIL redir_pc got %h want 0040", imem_addr); end
    checks++; if (id_instr !== BUBBLE || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_bubble got %h v=%b want 3000 0", id_instr, id_valid); end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    checks++; if (id_instr !== 16'h0A5A || id_pc_next !== 16'h0042) begin errors++; $display("[TB] FAIL redir_fetch got %h/%h want 0a5a/0042", id_instr, id_pc_next); end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    step();
    checks++; if (imem_addr !== 16'h0042 || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_only got pc=%h v=%b want 0042 0", imem_addr, id_valid); end
  endtask

  task automatic test_wrap();
    mem[16'hFFFE] = 16'h0111;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    checks++; if (id_instr !== 16'h0111 || id_pc_next !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_pcn got %h/%h want 0111/0000", id_instr, id_pc_next); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_addr got %h want 0000", imem_addr); end
  endtask

  task automatic test_random();
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'($urandom);
      if (mem[a][15:12] == 4'hF) mem[a][15:12] = 4'hE;
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, 16'($urandom));
      step();
      checks++;
      if (imem_addr !== m_pc || id_instr !== m_instr || id_pc_next !== m_pcn ||
          id_valid !== m_valid || halted !== m_halted || fetch_count !== exp_count() ||
          opcode !== m_instr[15:12] || func !== m_instr[3:0]) begin
        errors++;
        $display("[TB] FAIL random_%0d got pc=%h i=%h n=%h v=%b h=%b c=%h want pc=%h i=%h n=%h v=%b h=%b c=%h",
                 i, imem_addr, id_instr, id_pc_next, id_valid, halted, fetch_count,
                 m_pc, m_instr, m_pcn, m_valid, m_halted, exp_count());
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] frozen_pc, frozen_cnt;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    mem[m_pc] = 16'hF000;
    step();
    checks++; if (opcode !== 4'hF || id_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_in_id got op=%h v=%b want f 1", opcode, id_valid); end
    step();
    checks++; if (halted !== 1'b1 || id_instr !== BUBBLE || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_enter got h=%b i=%h v=%b want 1 3000 0", halted, id_instr, id_valid); end
    frozen_pc = m_pc; frozen_cnt = exp_count();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      step();
      checks++;
      if (imem_addr !== frozen_pc || halted !== 1'b1 || id_instr !== BUBBLE || fetch_count !== frozen_cnt) begin
        errors++;
        $display("[TB] FAIL halt_frozen_%0d got pc=%h h=%b i=%h c=%h want %h 1 3000 %h", i, imem_addr, halted, id_instr, fetch_count, frozen_pc, frozen_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    step(); step();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (imem_addr !== 16'h0000 || id_instr !== BUBBLE || id_pc_next !== 16'h0000) begin errors++; $display("[TB] FAIL rst_stall_regs got %h %h %h want 0000 3000 0000", imem_addr, id_instr, id_pc_next); end
    checks++; if (id_valid !== 1'b0 || fetch_count !== 16'h0000) begin errors++; $display("[TB] FAIL rst_stall_flags got v=%b c=%h want 0 0000", id_valid, fetch_count); end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    #2 reset = 1'b1;
    step();
    checks++; if (id_instr !== mem[16'h0000] || imem_addr !== 16'h0002 || id_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall_restart got %h pc=%h v=%b want %h 0002 1", id_instr, imem_addr, id_valid, mem[16'h0000]); end
  endtask

  task automatic test_reset_mid_halt();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    mem[m_pc] = 16'hF00F;
    step(); step();
    checks++; if (halted !== m_halted) begin errors++; $display("[TB] FAIL halt2_enter got %b want %b", halted, m_halted); end
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0000 || id_instr !== BUBBLE || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_halt_regs got h=%b pc=%h i=%h v=%b want 0 0000 3000 0", halted, imem_addr, id_instr, id_valid); end
    checks++; if (fetch_count !== 16'h0000 || id_pc_next !== 16'h0000) begin errors++; $display("[TB] FAIL rst_halt_misc got c=%h n=%h want 0000 0000", fetch_count, id_pc_next); end
    #2 reset = 1'b1;
    step();
    checks++; if (id_instr !== m_instr || imem_addr !== 16'h0002 || halted !== m_halted) begin errors++; $display("[TB] FAIL rst_halt_restart got i=%h pc=%h h=%b want %h 0002 %b", id_instr, imem_addr, halted, m_instr, m_halted); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid_stall();
    test_reset_mid_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
